// File: rtl/parallel_rx_capture.sv
// Receive side of the 8-bit parallel link: synchronises PAR_CLK/PAR_FLAG/PAR_DATA into CLK
// and writes each captured byte into a frame buffer. Optional watchdog: PARRX_TIMEOUT_EN.
module parallel_rx_capture #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned MAX_BYTES      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  PAR_CLK,
  input  logic                  PAR_FLAG,
  input  logic [DATA_WIDTH-1:0] PAR_DATA,
  input  logic                  ENABLE,
  output logic                  WR_EN,
  output logic [ADDR_WIDTH-1:0] WR_ADDR,
  output logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  BUSY,
  output logic                  FRAME_VALID,
  output logic [ADDR_WIDTH:0]   BYTE_COUNT,
`ifdef PARRX_TIMEOUT_EN
  output logic                  TIMEOUT,
`endif
  output logic                  OVERFLOW
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES);

  if (MAX_BYTES > (1 << ADDR_WIDTH) || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("parallel_rx_capture: MAX_BYTES exceeds buffer or TIMEOUT_CYCLES too small");
  end

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t state, state_d;

  logic                  par_clk_s1, par_clk_s2, par_clk_s3;
  logic                  par_flag_s1, par_flag_s2, par_flag_s3;
  logic [DATA_WIDTH-1:0] par_data_s1, par_data_s2;
  logic [1:0]            prime;
  logic                  sync_ok, clk_rise, flag_rise, flag_fall;

  logic [CNT_W-1:0]      count, count_d;
  logic                  wr_en_d, frame_valid_d, overflow_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d;
  logic [CNT_W-1:0]      byte_count_d;

`ifdef PARRX_TIMEOUT_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] wdog, wdog_d;
  logic              timeout_d, clk_fall, clk_edge;
`endif

  // Synchroniser chains; prime gates edge detection until stage 3 holds a real sample,
  // so a flag already high across reset is not mistaken for a fresh frame start.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      par_clk_s1  <= 1'b0;
      par_clk_s2  <= 1'b0;
      par_clk_s3  <= 1'b0;
      par_flag_s1 <= 1'b0;
      par_flag_s2 <= 1'b0;
      par_flag_s3 <= 1'b0;
      par_data_s1 <= '0;
      par_data_s2 <= '0;
      prime       <= 2'd0;
    end else begin
      par_clk_s1  <= PAR_CLK;
      par_clk_s2  <= par_clk_s1;
      par_clk_s3  <= par_clk_s2;
      par_flag_s1 <= PAR_FLAG;
      par_flag_s2 <= par_flag_s1;
      par_flag_s3 <= par_flag_s2;
      par_data_s1 <= PAR_DATA;
      par_data_s2 <= par_data_s1;
      if (prime != 2'd3) prime <= prime + 2'd1;
    end
  end

  assign sync_ok   = (prime == 2'd3);
  assign clk_rise  = sync_ok &  par_clk_s2  & ~par_clk_s3;
  assign flag_rise = sync_ok &  par_flag_s2 & ~par_flag_s3;
  assign flag_fall = sync_ok & ~par_flag_s2 &  par_flag_s3;
`ifdef PARRX_TIMEOUT_EN
  assign clk_fall  = sync_ok & ~par_clk_s2  &  par_clk_s3;
  assign clk_edge  = clk_rise | clk_fall;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= S_IDLE;
      count       <= '0;
      WR_EN       <= 1'b0;
      WR_ADDR     <= '0;
      WR_DATA     <= '0;
      BUSY        <= 1'b0;
      FRAME_VALID <= 1'b0;
      BYTE_COUNT  <= '0;
      OVERFLOW    <= 1'b0;
`ifdef PARRX_TIMEOUT_EN
      wdog        <= '0;
      TIMEOUT     <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      count       <= count_d;
      WR_EN       <= wr_en_d;
      WR_ADDR     <= wr_addr_d;
      WR_DATA     <= wr_data_d;
      BUSY        <= (state_d == S_CAPTURE);
      FRAME_VALID <= frame_valid_d;
      BYTE_COUNT  <= byte_count_d;
      OVERFLOW    <= overflow_d;
`ifdef PARRX_TIMEOUT_EN
      wdog        <= wdog_d;
      TIMEOUT     <= timeout_d;
`endif
    end
  end

  // Next state and next register values; FRAME_VALID is raised on the transition into DONE.
  always_comb begin
    state_d       = state;
    count_d       = count;
    wr_en_d       = 1'b0;
    wr_addr_d     = WR_ADDR;
    wr_data_d     = WR_DATA;
    frame_valid_d = 1'b0;
    byte_count_d  = BYTE_COUNT;
    overflow_d    = OVERFLOW;
`ifdef PARRX_TIMEOUT_EN
    wdog_d        = wdog;
    timeout_d     = TIMEOUT;
`endif
    case (state)
      S_IDLE: begin
        if (flag_rise && ENABLE) begin
          state_d    = S_CAPTURE;
          count_d    = '0;
          overflow_d = 1'b0;
`ifdef PARRX_TIMEOUT_EN
          wdog_d     = '0;
          timeout_d  = 1'b0;
`endif
        end
      end
      S_CAPTURE: begin
        // Stage 3 still holds the flag when its fall coincides with a clock rise.
        if (clk_rise && (par_flag_s2 || par_flag_s3)) begin
          if (count < CNT_MAX) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_WIDTH'(count);
            wr_data_d = par_data_s2;
            count_d   = count + CNT_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
`ifdef PARRX_TIMEOUT_EN
        wdog_d = clk_edge ? '0 : wdog + WDOG_W'(1);
`endif
        if (flag_fall) begin
          state_d       = S_DONE;
          frame_valid_d = 1'b1;
          byte_count_d  = count_d;
        end
`ifdef PARRX_TIMEOUT_EN
        else if (!clk_edge && wdog == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = S_DONE;
          frame_valid_d = 1'b1;
          byte_count_d  = count_d;
          timeout_d     = 1'b1;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_parallel_rx_capture.sv
// Directed bench for parallel_rx_capture (MAX_BYTES=4, TIMEOUT_CYCLES=16); timeout
// scenario runs only when PARRX_TIMEOUT_EN is defined.
module tb_parallel_rx_capture;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        PAR_CLK, PAR_FLAG, ENABLE;
  logic [7:0]  PAR_DATA;
  logic        WR_EN, BUSY, FRAME_VALID, OVERFLOW;
  logic [11:0] WR_ADDR;
  logic [7:0]  WR_DATA;
  logic [12:0] BYTE_COUNT;
`ifdef PARRX_TIMEOUT_EN
  logic        TIMEOUT;
`endif

  int errors = 0;
  int checks = 0;

  logic [11:0] wa[$];
  logic [7:0]  wd[$];
  int          fv_cnt = 0;
  logic [12:0] fv_bc;
  logic        fv_ovf;

  parallel_rx_capture #(
    .DATA_WIDTH(8), .ADDR_WIDTH(12), .MAX_BYTES(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK), .RESET(RESET), .PAR_CLK(PAR_CLK), .PAR_FLAG(PAR_FLAG),
    .PAR_DATA(PAR_DATA), .ENABLE(ENABLE), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .BUSY(BUSY), .FRAME_VALID(FRAME_VALID),
    .BYTE_COUNT(BYTE_COUNT),
`ifdef PARRX_TIMEOUT_EN
    .TIMEOUT(TIMEOUT),
`endif
    .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Record every write strobe and frame-end pulse, sampled away from the active edge.
  always @(negedge CLK) begin
    if (WR_EN) begin
      wa.push_back(WR_ADDR);
      wd.push_back(WR_DATA);
    end
    if (FRAME_VALID) begin
      fv_cnt++;
      fv_bc  = BYTE_COUNT;
      fv_ovf = OVERFLOW;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One link byte: data set while PAR_CLK is low, 4-cycle low and high phases.
  task automatic send_byte(input logic [7:0] d);
    PAR_DATA = d;
    wait_n(4);
    PAR_CLK = 1'b1;
    wait_n(4);
    PAR_CLK = 1'b0;
  endtask

  task automatic run_frame(input int n, input logic [7:0] d0);
    PAR_FLAG = 1'b1;
    wait_n(4);
    for (int i = 0; i < n; i++) send_byte(8'(d0 + 8'(i * 17)));
    wait_n(4);
    PAR_FLAG = 1'b0;
    wait_n(10);
  endtask

  task automatic chk_writes(input string tag, input int w0, input int n, input logic [7:0] d0);
    chk({tag, "_nwr"}, 32'(wa.size() - w0), 32'(n));
    for (int i = 0; i < n && (w0 + i) < wa.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wa[w0 + i]), 32'(i));
      chk($sformatf("%s_data%0d", tag, i), 32'(wd[w0 + i]), 32'(8'(d0 + 8'(i * 17))));
    end
  endtask

  int w0, f0;

  initial begin
    RESET = 1'b1; PAR_CLK = 1'b0; PAR_FLAG = 1'b0; PAR_DATA = 8'h00; ENABLE = 1'b0;
    wait_n(3);
    chk("rst_wr_en",  32'(WR_EN), 32'd0);
    chk("rst_busy",   32'(BUSY), 32'd0);
    chk("rst_fv",     32'(FRAME_VALID), 32'd0);
    chk("rst_bc",     32'(BYTE_COUNT), 32'd0);
    chk("rst_ovf",    32'(OVERFLOW), 32'd0);
    chk("rst_addr",   32'(WR_ADDR), 32'd0);
    RESET = 1'b0;
    wait_n(5);

    // Basic 4-byte frame A1,B2,C3,D4.
    ENABLE = 1'b1;
    w0 = wa.size(); f0 = fv_cnt;
    run_frame(4, 8'hA1);
    chk_writes("f4", w0, 4, 8'hA1);
    chk("f4_fv",  32'(fv_cnt - f0), 32'd1);
    chk("f4_bc",  32'(fv_bc), 32'd4);
    chk("f4_ovf", 32'(fv_ovf), 32'd0);
    chk("f4_busy_after", 32'(BUSY), 32'd0);

    // 6 bytes into a 4-byte buffer.
    w0 = wa.size(); f0 = fv_cnt;
    run_frame(6, 8'h10);
    chk_writes("ovf", w0, 4, 8'h10);
    chk("ovf_fv",  32'(fv_cnt - f0), 32'd1);
    chk("ovf_bc",  32'(fv_bc), 32'd4);
    chk("ovf_ovf", 32'(fv_ovf), 32'd1);
    chk("ovf_hold", 32'(OVERFLOW), 32'd1);

    w0 = wa.size(); f0 = fv_cnt;
    run_frame(2, 8'h50);
    chk_writes("f2", w0, 2, 8'h50);
    chk("f2_bc",  32'(fv_bc), 32'd2);
    chk("f2_ovf", 32'(OVERFLOW), 32'd0);

    // Reset after 2 bytes of a 5-byte frame; the remainder must be ignored.
    w0 = wa.size(); f0 = fv_cnt;
    PAR_FLAG = 1'b1;
    wait_n(4);
    send_byte(8'h31);
    send_byte(8'h42);
    wait_n(1);
    RESET = 1'b1;
    wait_n(2);
    chk("mrst_busy", 32'(BUSY), 32'd0);
    chk("mrst_bc",   32'(BYTE_COUNT), 32'd0);
    chk("mrst_addr", 32'(WR_ADDR), 32'd0);
    chk("mrst_data", 32'(WR_DATA), 32'd0);
    RESET = 1'b0;
    send_byte(8'h53);
    chk("mrst_busy_post", 32'(BUSY), 32'd0);
    send_byte(8'h64);
    send_byte(8'h75);
    wait_n(4);
    PAR_FLAG = 1'b0;
    wait_n(10);
    chk_writes("mrst", w0, 2, 8'h31);
    chk("mrst_fv", 32'(fv_cnt - f0), 32'd0);
    chk("mrst_bc_after", 32'(BYTE_COUNT), 32'd0);

    w0 = wa.size(); f0 = fv_cnt;
    run_frame(3, 8'h70);
    chk_writes("f3", w0, 3, 8'h70);
    chk("f3_fv", 32'(fv_cnt - f0), 32'd1);
    chk("f3_bc", 32'(fv_bc), 32'd3);

    // Flag rises while disabled; enabling mid-frame must not join it.
    ENABLE = 1'b0;
    w0 = wa.size(); f0 = fv_cnt;
    PAR_FLAG = 1'b1;
    wait_n(4);
    send_byte(8'hE0);
    ENABLE = 1'b1;
    send_byte(8'hE1);
    send_byte(8'hE2);
    wait_n(4);
    PAR_FLAG = 1'b0;
    wait_n(10);
    chk("dis_nwr", 32'(wa.size() - w0), 32'd0);
    chk("dis_fv",  32'(fv_cnt - f0), 32'd0);
    run_frame(2, 8'h90);
    chk_writes("en", w0, 2, 8'h90);
    chk("en_fv", 32'(fv_cnt - f0), 32'd1);
    chk("en_bc", 32'(fv_bc), 32'd2);

    // Zero-byte frame: flag pulse of 10 CLK with PAR_CLK low.
    w0 = wa.size(); f0 = fv_cnt;
    PAR_FLAG = 1'b1;
    wait_n(5);
    chk("zb_busy", 32'(BUSY), 32'd1);
    wait_n(5);
    PAR_FLAG = 1'b0;
    wait_n(10);
    chk("zb_nwr", 32'(wa.size() - w0), 32'd0);
    chk("zb_fv",  32'(fv_cnt - f0), 32'd1);
    chk("zb_bc",  32'(fv_bc), 32'd0);

`ifdef PARRX_TIMEOUT_EN
    // Link clock stalls after 3 bytes with the flag still high.
    w0 = wa.size(); f0 = fv_cnt;
    PAR_FLAG = 1'b1;
    wait_n(4);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h23);
    wait_n(12);
    chk("to_early_fv", 32'(fv_cnt - f0), 32'd0);
    wait_n(20);
    chk_writes("to", w0, 3, 8'h01);
    chk("to_fv",      32'(fv_cnt - f0), 32'd1);
    chk("to_bc",      32'(fv_bc), 32'd3);
    chk("to_timeout", 32'(TIMEOUT), 32'd1);
    PAR_FLAG = 1'b0;
    wait_n(10);
    chk("to_fv_after_fall", 32'(fv_cnt - f0), 32'd1);
    run_frame(1, 8'h05);
    chk("to_clear", 32'(TIMEOUT), 32'd0);
    chk("to_next_bc", 32'(fv_bc), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
